ltl_monitor_ctrl: RTL and testbench

- Sequencer for one generated LTL automaton cluster (for example, an 11-STE cluster with 4 report outputs).
- Accepts a valid/ready trace-symbol stream and performs the automaton's reset/start-of-data arming.
- Gates `run` per symbol.
- Captures report vectors one cycle after each symbol and queues them as indexed report events for the monitor aggregator.

---
 rtl/ltl_mon_pkg.sv | 23 ++
 rtl/ltl_monitor_ctrl_if.sv | 25 ++
 rtl/ltl_mon_evt_fifo.sv | 50 +++++
 rtl/ltl_monitor_ctrl.sv | 138 +++++++++++++
 tb/tb_ltl_monitor_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ltl_mon_pkg.sv
// Shared types and default widths for the LTL automaton-cluster sequencer.
package ltl_mon_pkg;

    localparam int LTL_SYM_W     = 8;
    localparam int LTL_NUM_REP   = 4;
    localparam int LTL_IDX_W     = 16;
    localparam int LTL_EVT_DEPTH = 4;
    localparam int LTL_TIMEOUT   = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } ltl_state_e;

    typedef struct packed {
        logic [LTL_IDX_W-1:0]   index;
        logic [LTL_NUM_REP-1:0] report;
    } ltl_evt_t;

endpackage

// File: rtl/ltl_monitor_ctrl_if.sv
// Trace-symbol input stream and report-event output stream of the sequencer.
interface ltl_monitor_ctrl_if #(
    parameter int SYM_W   = 8,
    parameter int NUM_REP = 4,
    parameter int IDX_W   = 16
);
    logic               sym_valid;
    logic               sym_ready;
    logic [SYM_W-1:0]   sym_data;
    logic               sym_last;
    logic               evt_valid;
    logic               evt_ready;
    logic [IDX_W-1:0]   evt_index;
    logic [NUM_REP-1:0] evt_report;

    modport master (
        output sym_valid, sym_data, sym_last, evt_ready,
        input  sym_ready, evt_valid, evt_index, evt_report
    );

    modport slave (
        input  sym_valid, sym_data, sym_last, evt_ready,
        output sym_ready, evt_valid, evt_index, evt_report
    );
endinterface

// File: rtl/ltl_mon_evt_fifo.sv
// Show-ahead synchronous FIFO with a free-slot count; push and pop may coincide even when full.
module ltl_mon_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 20,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] rd_data,
    output logic         empty,
    output logic [PW:0]  free
);
    localparam int FW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          wr_en, rd_en;

    assign empty   = (count == '0);
    assign free    = FW'(DEPTH) - count;
    assign rd_data = mem[rd_ptr];
    assign rd_en   = pop && !empty;
    // A full FIFO still accepts a write when the head is leaving in the same cycle.
    assign wr_en   = push && ((count != FW'(DEPTH)) || rd_en);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ltl_monitor_ctrl.sv
// Sequencer for one LTL automaton cluster: arms the automaton, gates run per symbol, queues reports.
// Optional idle timeout is built when LTL_MON_TIMEOUT_EN is defined.
module ltl_monitor_ctrl
    import ltl_mon_pkg::*;
#(
    parameter int SYM_W     = LTL_SYM_W,
    parameter int NUM_REP   = LTL_NUM_REP,
    parameter int IDX_W     = LTL_IDX_W,
    parameter int EVT_DEPTH = LTL_EVT_DEPTH,
    parameter int TIMEOUT   = LTL_TIMEOUT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_start,
    ltl_monitor_ctrl_if.slave  bus,
    output logic               aut_reset,
    output logic               aut_run,
    output logic [SYM_W-1:0]   aut_symbols,
    input  logic [NUM_REP-1:0] aut_report,
    output logic               busy,
    output logic               done,
    output logic               evt_overflow,
    output logic               timeout
);
    localparam int PW = $clog2(EVT_DEPTH);
    localparam int FW = PW + 1;
    localparam logic [IDX_W-1:0] IDX_MAX = '1;

    ltl_state_e                 state;
    logic [IDX_W-1:0]           idx, cap_idx;
    logic                       cap_pending;
    logic [PW:0]                fifo_free;
    logic                       fifo_empty, free_ok, accept, push, pop;
    logic [IDX_W+NUM_REP-1:0]   rd_data;

    // One slot stays reserved for the report of the symbol currently in flight.
    assign free_ok       = fifo_free >= FW'(2);
    assign bus.sym_ready = ((state == ST_ARM) || (state == ST_RUN)) && free_ok;
    assign accept        = bus.sym_valid && bus.sym_ready;
    assign aut_run       = accept;
    assign aut_symbols   = bus.sym_data;
    assign aut_reset     = (state == ST_IDLE) || (state == ST_DONE) || ((state == ST_ARM) && !accept);

    assign push          = cap_pending && (aut_report != '0);
    assign pop           = bus.evt_valid && bus.evt_ready;
    assign bus.evt_valid = !fifo_empty;
    assign {bus.evt_index, bus.evt_report} = rd_data;

    ltl_mon_evt_fifo #(
        .DEPTH (EVT_DEPTH),
        .W     (IDX_W + NUM_REP)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({cap_idx, aut_report}),
        .pop       (pop),
        .rd_data   (rd_data),
        .empty     (fifo_empty),
        .free      (fifo_free)
    );

`ifdef LTL_MON_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    logic [TO_W-1:0] idle_cnt;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            evt_overflow <= 1'b0;
            idx          <= '0;
            cap_idx      <= '0;
            cap_pending  <= 1'b0;
`ifdef LTL_MON_TIMEOUT_EN
            timeout      <= 1'b0;
            idle_cnt     <= '0;
`endif
        end else begin
            done        <= 1'b0;
            cap_pending <= accept;
            if (accept) begin
                cap_idx <= idx;
                if (idx != IDX_MAX) idx <= idx + 1'b1;
                if (idx >= IDX_MAX - 1'b1) evt_overflow <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (cmd_start) begin
                        state        <= ST_ARM;
                        busy         <= 1'b1;
                        idx          <= '0;
                        evt_overflow <= 1'b0;
`ifdef LTL_MON_TIMEOUT_EN
                        timeout      <= 1'b0;
                        idle_cnt     <= '0;
`endif
                    end
                end
                ST_ARM, ST_RUN: begin
                    if (accept) state <= bus.sym_last ? ST_DRAIN : ST_RUN;
`ifdef LTL_MON_TIMEOUT_EN
                    // A stalled-but-valid symbol neither counts as idle nor restarts the count.
                    if (accept) begin
                        idle_cnt <= '0;
                    end else if (!bus.sym_valid) begin
                        if (idle_cnt == TO_LAST) begin
                            idle_cnt <= '0;
                            timeout  <= 1'b1;
                            state    <= ST_DRAIN;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
`endif
                end
                ST_DRAIN: begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ltl_monitor_ctrl.sv
// Directed bench for ltl_monitor_ctrl; report events are checked against a queue of expected events.
`timescale 1ns/1ps
module tb_ltl_monitor_ctrl;
    import ltl_mon_pkg::*;

`ifdef LTL_MON_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 1024;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_start;
    logic       aut_reset, aut_run;
    logic [7:0] aut_symbols;
    logic [3:0] aut_report;
    logic       busy, done, evt_overflow, timeout;

    ltl_monitor_ctrl_if ifc ();

    ltl_monitor_ctrl #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_start    (cmd_start),
        .bus          (ifc.slave),
        .aut_reset    (aut_reset),
        .aut_run      (aut_run),
        .aut_symbols  (aut_symbols),
        .aut_report   (aut_report),
        .busy         (busy),
        .done         (done),
        .evt_overflow (evt_overflow),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    ltl_evt_t   exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         exp_idx = 0;
    int         run_cnt = 0;
    logic [3:0] cur_rep = '0;
    logic [3:0] rep_s = '0;
    logic       run_s = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Automaton stand-in: report is registered, appearing the cycle after a run.
    always @(negedge clk) begin
        run_s = aut_run;
        rep_s = cur_rep;
        if (aut_run === 1'b1) run_cnt++;
    end

    always @(posedge clk) begin
        if (reset) aut_report <= '0;
        else       aut_report <= run_s ? rep_s : 4'h0;
    end

    // Event monitor
    always @(negedge clk) begin
        if (!reset && ifc.evt_valid === 1'b1 && ifc.evt_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL evt_unexpected got idx=%0d rep=%b expected none", ifc.evt_index, ifc.evt_report);
            end else begin
                ltl_evt_t e;
                e = exp_q.pop_front();
                check("evt_index", 32'(ifc.evt_index), 32'(e.index));
                check("evt_report", 32'(ifc.evt_report), 32'(e.report));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        exp_idx = 0;
    endtask

    task automatic send(input logic [7:0] d, input logic last, input logic [3:0] rep, input int gap);
        int n = 0;
        ifc.sym_valid = 1'b1;
        ifc.sym_data  = d;
        ifc.sym_last  = last;
        cur_rep       = rep;
        @(negedge clk);
        while (ifc.sym_ready !== 1'b1 && n < 100) begin
            check("stall_run", 32'(aut_run), 32'd0);
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL send_wait got=not_accepted expected=accepted sym=%h", d);
            ifc.sym_valid = 1'b0;
            ifc.sym_last  = 1'b0;
            tick();
            return;
        end
        check("accept_run", 32'(aut_run), 32'd1);
        check("accept_areset", 32'(aut_reset), 32'd0);
        check("sym_pass", 32'(aut_symbols), 32'(d));
        if (rep != 4'h0) exp_q.push_back(ltl_evt_t'{index: exp_idx[15:0], report: rep});
        exp_idx++;
        tick();
        ifc.sym_valid = 1'b0;
        ifc.sym_last  = 1'b0;
        cur_rep       = 4'h0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            check("gap_run", 32'(aut_run), 32'd0);
            check("gap_areset", 32'(aut_reset), 32'd0);
            tick();
        end
    endtask

    // Called in the DRAIN cycle right after the last accept.
    task automatic wait_done();
        @(negedge clk);
        check("drain_done", 32'(done), 32'd0);
        check("drain_busy", 32'(busy), 32'd1);
        tick();
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd1);
        tick();
        @(negedge clk);
        check("done_clear", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_areset", 32'(aut_reset), 32'd1);
        tick();
    endtask

    task automatic drain_check(input string name);
        repeat (8) tick();
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        cmd_start     = 1'b0;
        ifc.sym_valid = 1'b0;
        ifc.sym_data  = '0;
        ifc.sym_last  = 1'b0;
        ifc.evt_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // reset state
        @(negedge clk);
        check("rst_areset", 32'(aut_reset), 32'd1);
        check("rst_run", 32'(aut_run), 32'd0);
        check("rst_ready", 32'(ifc.sym_ready), 32'd0);
        check("rst_evt_valid", 32'(ifc.evt_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf", 32'(evt_overflow), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        tick();

        // 1: basic three-symbol trace, no reports
        ifc.evt_ready = 1'b1;
        start();
        @(negedge clk);
        check("arm_areset", 32'(aut_reset), 32'd1);
        check("arm_ready", 32'(ifc.sym_ready), 32'd1);
        check("arm_busy", 32'(busy), 32'd1);
        tick();
        run_cnt = 0;
        send(8'h05, 1'b0, 4'h0, 0);
        send(8'h25, 1'b0, 4'h0, 0);
        send(8'h80, 1'b1, 4'h0, 0);
        wait_done();
        check("t1_run_cycles", 32'(run_cnt), 32'd3);
        drain_check("t1_no_events");

        // 2: single nonzero report at index 2
        start();
        send(8'h11, 1'b0, 4'h0, 0);
        send(8'h22, 1'b0, 4'h0, 0);
        send(8'h33, 1'b0, 4'b0100, 0);
        send(8'h44, 1'b1, 4'h0, 0);
        wait_done();
        drain_check("t2_drained");

        // 3: consumer stalled, reports every symbol, back-pressure at free<2
        ifc.evt_ready = 1'b0;
        start();
        send(8'hA0, 1'b0, 4'h1, 0);
        send(8'hA1, 1'b0, 4'h2, 0);
        send(8'hA2, 1'b0, 4'h3, 0);
        tick();
        @(negedge clk);
        check("t3_ready_low", 32'(ifc.sym_ready), 32'd0);
        check("t3_evt_valid", 32'(ifc.evt_valid), 32'd1);
        check("t3_head_idx", 32'(ifc.evt_index), 32'd0);
        tick();
        fork
            send(8'hA3, 1'b1, 4'h8, 0);
            begin
                repeat (4) tick();
                ifc.evt_ready = 1'b1;
            end
        join
        wait_done();
        drain_check("t3_drained");

        // 4: gaps of 5 idle cycles between symbols
        start();
        send(8'h01, 1'b0, 4'h1, 5);
        send(8'h02, 1'b0, 4'h2, 5);
        send(8'h03, 1'b1, 4'h4, 0);
        wait_done();
        drain_check("t4_drained");

        // 5: reset mid-RUN with two queued events
        ifc.evt_ready = 1'b0;
        start();
        send(8'hB0, 1'b0, 4'h1, 0);
        send(8'hB1, 1'b0, 4'h2, 0);
        tick();
        @(negedge clk);
        check("t5_queued", 32'(ifc.evt_valid), 32'd1);
        tick();
        reset = 1'b1;
        exp_q.delete();
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("t5_evt_valid", 32'(ifc.evt_valid), 32'd0);
        check("t5_areset", 32'(aut_reset), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_ready", 32'(ifc.sym_ready), 32'd0);
        ifc.evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t5_no_done", 32'(done), 32'd0);
            tick();
            @(negedge clk);
        end
        tick();

`ifdef LTL_MON_TIMEOUT_EN
        // 6: idle timeout ends the trace
        start();
        send(8'h77, 1'b0, 4'h0, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t6_pre", 32'(timeout), 32'd0);
            tick();
        end
        @(negedge clk);
        check("t6_set", 32'(timeout), 32'd1);
        check("t6_busy", 32'(busy), 32'd1);
        check("t6_nodone", 32'(done), 32'd0);
        tick();
        @(negedge clk);
        check("t6_done", 32'(done), 32'd1);
        tick();
        @(negedge clk);
        check("t6_sticky", 32'(timeout), 32'd1);
        tick();
        start();
        @(negedge clk);
        check("t6_cleared", 32'(timeout), 32'd0);
        tick();
        send(8'h78, 1'b1, 4'h0, 0);
        wait_done();
`else
        @(negedge clk);
        check("timeout_tied", 32'(timeout), 32'd0);
        tick();
`endif

        check("final_ovf", 32'(evt_overflow), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
